// File: rtl/itch_result_axis_tx.sv
// AXI-Stream transmitter for parsed ITCH results. Each result is sent as an
// 11-word record. Two record slots (active and pending) absorb back-pressure.
module itch_result_axis_tx #(
  parameter int          C_M_AXIS_TDATA_WIDTH = 32,
  parameter logic [7:0]  SYNC_BYTE            = 8'hA5
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic                              latched_valid,
  input  logic [3:0]                        latched_type,
  input  logic [63:0]                       latched_order_ref,
  input  logic                              latched_side,
  input  logic [31:0]                       latched_shares,
  input  logic [31:0]                       latched_price,
  input  logic [63:0]                       latched_new_order_ref,
  input  logic [47:0]                       latched_timestamp,
  input  logic [63:0]                       latched_misc_data,
  input  logic                              tx_enable,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [3:0]                        M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic                              busy,
  output logic [15:0]                       drop_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [3:0] LAST_BEAT = 4'd10;

  typedef struct packed {
    logic [7:0]  seq;
    logic [3:0]  mtype;
    logic        side;
    logic [63:0] order_ref;
    logic [31:0] shares;
    logic [31:0] price;
    logic [63:0] new_order_ref;
    logic [47:0] ts;
    logic [63:0] misc;
  } rec_t;

  logic [0:0]  state, state_n;
  logic [3:0]  beat, beat_n;
  logic [7:0]  seq, seq_n;
  logic [15:0] drop_n;
  rec_t        active, active_n, pending, pending_n, incoming;
  logic        active_valid, active_valid_n, pending_valid, pending_valid_n;
  logic        hs, last_hs;
  logic [31:0] word;

  assign hs      = M_AXIS_TVALID && M_AXIS_TREADY;
  assign last_hs = hs && (beat == LAST_BEAT);

  always_comb begin
    incoming.seq           = seq;
    incoming.mtype         = latched_type;
    incoming.side          = latched_side;
    incoming.order_ref     = latched_order_ref;
    incoming.shares        = latched_shares;
    incoming.price         = latched_price;
    incoming.new_order_ref = latched_new_order_ref;
    incoming.ts            = latched_timestamp;
    incoming.misc          = latched_misc_data;
  end

  // The slot shift on the final handshake is resolved before the capture so a
  // result arriving on that same cycle lands in the slot just freed.
  always_comb begin
    active_n        = active;
    pending_n       = pending;
    active_valid_n  = active_valid;
    pending_valid_n = pending_valid;
    state_n         = state;
    beat_n          = beat;
    seq_n           = seq;
    drop_n          = drop_count;

    if (hs && !last_hs)
      beat_n = beat + 4'd1;

    if (last_hs) begin
      active_n        = pending;
      active_valid_n  = pending_valid;
      pending_valid_n = 1'b0;
    end

    if (latched_valid) begin
      seq_n = seq + 8'd1;
      if (!active_valid_n) begin
        active_n       = incoming;
        active_valid_n = 1'b1;
      end else if (!pending_valid_n) begin
        pending_n       = incoming;
        pending_valid_n = 1'b1;
      end else if (drop_count != 16'hFFFF) begin
        drop_n = drop_count + 16'd1;
      end
    end

    if ((state == IDLE) || last_hs) begin
      beat_n  = 4'd0;
      state_n = (active_valid_n && tx_enable) ? SEND : IDLE;
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state         <= IDLE;
      beat          <= 4'd0;
      seq           <= 8'd0;
      drop_count    <= 16'd0;
      active        <= '0;
      pending       <= '0;
      active_valid  <= 1'b0;
      pending_valid <= 1'b0;
    end else begin
      state         <= state_n;
      beat          <= beat_n;
      seq           <= seq_n;
      drop_count    <= drop_n;
      active        <= active_n;
      pending       <= pending_n;
      active_valid  <= active_valid_n;
      pending_valid <= pending_valid_n;
    end
  end

  // The active slot is frozen while sending, so the selected word stays
  // stable across stall cycles without an output register.
  always_comb begin
    word = '0;
    case (beat)
      4'd0:    word = {SYNC_BYTE, 4'h0, active.mtype, 7'h0, active.side, active.seq};
      4'd1:    word = {16'h0, active.ts[47:32]};
      4'd2:    word = active.ts[31:0];
      4'd3:    word = active.order_ref[63:32];
      4'd4:    word = active.order_ref[31:0];
      4'd5:    word = active.shares;
      4'd6:    word = active.price;
      4'd7:    word = active.new_order_ref[63:32];
      4'd8:    word = active.new_order_ref[31:0];
      4'd9:    word = active.misc[63:32];
      4'd10:   word = active.misc[31:0];
      default: word = '0;
    endcase
  end

  assign M_AXIS_TVALID = (state == SEND);
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? word : '0;
  assign M_AXIS_TLAST  = M_AXIS_TVALID && (beat == LAST_BEAT);
  assign M_AXIS_TSTRB  = M_AXIS_TVALID ? 4'hF : 4'h0;
  assign busy          = active_valid || pending_valid;

endmodule
